// File: rtl/agdc_ctrl_param.sv
// Garage-door motor controller (Moore FSM).
// Drives the up/down motor enables from the limit switches, the push-button,
// and the beam-break sensor. Adds a motion watchdog, obstruction
// auto-reverse, stop-on-button while the door is moving, and a latched fault.
module agdc_ctrl_param #(
    parameter int MOVE_TIMEOUT = 1000,
    parameter int TMR_W        = $clog2(MOVE_TIMEOUT + 1),
    parameter bit REVERSE_EN   = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Activate,
    input  logic       UP_Max,
    input  logic       DN_Max,
    input  logic       Obstruct,
    input  logic       Fault_Clr,
    output logic       UP_M,
    output logic       DN_M,
    output logic       Fault,
    output logic [2:0] State
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] MV_UP = 3'd1;
    localparam logic [2:0] MV_DN = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] FAULT = 3'd4;

    // Direction of the last interrupted travel: 0 = up, 1 = down.
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    // The watchdog fires on the last permitted motor-on cycle, so the motor
    // runs for at most MOVE_TIMEOUT cycles in one travel segment.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MOVE_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic             act_q;
    logic             act_rise;
    logic             last_dir;
    logic             last_dir_nxt;
    logic [TMR_W-1:0] timer;
    logic             timeout;
    logic             moving;

    assign act_rise = Activate & ~act_q;
    assign moving   = (state == MV_UP) || (state == MV_DN);
    assign timeout  = (timer == TMR_LAST);

    // Next-state selection; the sensor-conflict check overrides every state but FAULT.
    always_comb begin
        state_nxt    = state;
        last_dir_nxt = last_dir;
        if (state != FAULT && UP_Max && DN_Max) begin
            state_nxt = FAULT;
        end else begin
            case (state)
                IDLE: begin
                    if (act_rise) begin
                        state_nxt = UP_Max ? MV_DN : MV_UP;
                    end
                end
                MV_UP: begin
                    if (UP_Max) begin
                        state_nxt = IDLE;
                    end else if (act_rise) begin
                        state_nxt    = STOP;
                        last_dir_nxt = DIR_UP;
                    end else if (timeout) begin
                        state_nxt = FAULT;
                    end
                end
                MV_DN: begin
                    if (DN_Max) begin
                        state_nxt = IDLE;
                    end else if (Obstruct) begin
                        state_nxt    = REVERSE_EN ? MV_UP : STOP;
                        last_dir_nxt = DIR_DN;
                    end else if (act_rise) begin
                        state_nxt    = STOP;
                        last_dir_nxt = DIR_DN;
                    end else if (timeout) begin
                        state_nxt = FAULT;
                    end
                end
                STOP: begin
                    if (act_rise) begin
                        state_nxt = (last_dir == DIR_UP) ? MV_DN : MV_UP;
                    end
                end
                FAULT: begin
                    if (Fault_Clr) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, button history and direction memory.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            act_q    <= 1'b0;
            last_dir <= DIR_UP;
        end else begin
            state    <= state_nxt;
            act_q    <= Activate;
            last_dir <= last_dir_nxt;
        end
    end

    // Watchdog: restarts on every state change, counts motor-on cycles.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            timer <= '0;
        end else if (state_nxt != state) begin
            timer <= '0;
        end else if (moving && timer != TMR_MAX) begin
            timer <= timer + 1'b1;
        end
    end

    assign UP_M  = (state == MV_UP);
    assign DN_M  = (state == MV_DN);
    assign Fault = (state == FAULT);
    assign State = state;

endmodule

// File: tb/tb_agdc_ctrl_param.sv
// Bench for agdc_ctrl_param: two instances (auto-reverse on and off) share
// the same stimulus; a door-behaviour model predicts each next state.
module tb_agdc_ctrl_param;

    localparam int T = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_UP    = 3'd1;
    localparam logic [2:0] S_DN    = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic Activate = 1'b0, UP_Max = 1'b0, DN_Max = 1'b0, Obstruct = 1'b0, Fault_Clr = 1'b0;
    logic up0, dn0, f0, up1, dn1, f1;
    logic [2:0] st0, st1;

    int n_checks = 0;
    int n_errors = 0;
    bit drv_done = 1'b0;

    typedef struct packed {
        logic [2:0] s0;
        logic [2:0] s1;
    } exp_t;
    exp_t q[$];

    // Model state: door position intent per instance, not the RTL encoding of it.
    logic [2:0] m_st[2];
    bit         m_went_up[2];
    int         m_on[2];
    bit         m_btn;

    always #5 CLK = ~CLK;

    agdc_ctrl_param #(.MOVE_TIMEOUT(T), .REVERSE_EN(1'b1)) dut_rev (
        .CLK(CLK), .RST(RST), .Activate(Activate), .UP_Max(UP_Max), .DN_Max(DN_Max),
        .Obstruct(Obstruct), .Fault_Clr(Fault_Clr),
        .UP_M(up0), .DN_M(dn0), .Fault(f0), .State(st0));

    agdc_ctrl_param #(.MOVE_TIMEOUT(T), .REVERSE_EN(1'b0)) dut_stp (
        .CLK(CLK), .RST(RST), .Activate(Activate), .UP_Max(UP_Max), .DN_Max(DN_Max),
        .Obstruct(Obstruct), .Fault_Clr(Fault_Clr),
        .UP_M(up1), .DN_M(dn1), .Fault(f1), .State(st1));

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock edge of door behaviour for both instances.
    task automatic model_step(input bit rn, input bit a, input bit u, input bit d,
                              input bit o, input bit c);
        bit press;
        logic [2:0] nx;
        if (!rn) begin
            m_btn = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_st[k] = S_IDLE; m_went_up[k] = 1'b1; m_on[k] = 0;
            end
            return;
        end
        press = a && !m_btn;
        m_btn = a;
        for (int k = 0; k < 2; k++) begin
            nx = m_st[k];
            if (m_st[k] == S_FAULT) begin
                if (c) nx = S_IDLE;
            end else if (u && d) begin
                nx = S_FAULT;
            end else if (m_st[k] == S_IDLE) begin
                if (press) nx = u ? S_DN : S_UP;
            end else if (m_st[k] == S_STOP) begin
                if (press) nx = m_went_up[k] ? S_DN : S_UP;
            end else if (m_st[k] == S_UP) begin
                if (u) nx = S_IDLE;
                else if (press) begin nx = S_STOP; m_went_up[k] = 1'b1; end
                else if (m_on[k] + 1 == T) nx = S_FAULT;
            end else if (m_st[k] == S_DN) begin
                if (d) nx = S_IDLE;
                else if (o) begin nx = (k == 0) ? S_UP : S_STOP; m_went_up[k] = 1'b0; end
                else if (press) begin nx = S_STOP; m_went_up[k] = 1'b0; end
                else if (m_on[k] + 1 == T) nx = S_FAULT;
            end else begin
                nx = S_IDLE;
            end
            if (nx != m_st[k]) m_on[k] = 0;
            else if (nx == S_UP || nx == S_DN) m_on[k] = m_on[k] + 1;
            m_st[k] = nx;
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the expected result.
    task automatic cyc(input bit rn, input bit a, input bit u, input bit d,
                       input bit o, input bit c);
        exp_t e;
        @(negedge CLK);
        RST = rn; Activate = a; UP_Max = u; DN_Max = d; Obstruct = o; Fault_Clr = c;
        model_step(rn, a, u, d, o, c);
        e.s0 = m_st[0];
        e.s1 = m_st[1];
        q.push_back(e);
    endtask

    // Monitor: after every rising edge compare what the DUTs show against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rev_state", int'(st0), int'(e.s0));
                chk("rev_up_m",  int'(up0), int'(e.s0 == S_UP));
                chk("rev_dn_m",  int'(dn0), int'(e.s0 == S_DN));
                chk("rev_fault", int'(f0),  int'(e.s0 == S_FAULT));
                chk("stp_state", int'(st1), int'(e.s1));
                chk("stp_up_m",  int'(up1), int'(e.s1 == S_UP));
                chk("stp_dn_m",  int'(dn1), int'(e.s1 == S_DN));
                chk("stp_fault", int'(f1),  int'(e.s1 == S_FAULT));
                chk("motor_excl", int'((up0 & dn0) | (up1 & dn1)), 0);
            end
        end
    end

    initial begin
        bit a;
        bit u, d, o, c, rn;
        model_step(1'b0, 0, 0, 0, 0, 0);

        // Reset, then open from closed; reaching the top returns to idle.
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        cyc(1, 1, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);

        // Close from open; obstruction reverses (or stops), then button resumes.
        cyc(1, 1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);

        // Let motion run with no limit until the watchdog trips.
        cyc(1, 1, 0, 0, 0, 0);
        repeat (12) cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0);

        // Sensor conflict in idle and while closing; a held button must not restart.
        cyc(1, 1, 1, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);

        // Reset mid-travel drops the motor at once; held button counts once after release.
        cyc(1, 0, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        chk("async_rst_dn_m",  int'(dn0), 0);
        chk("async_rst_state", int'(st0), 0);
        chk("async_rst_fault", int'(f1),  0);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);

        // Randomized operation.
        a = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) a = ~a;
            u  = ($urandom_range(0, 9) == 0);
            d  = ($urandom_range(0, 9) == 0);
            o  = ($urandom_range(0, 6) == 0);
            c  = ($urandom_range(0, 5) == 0);
            rn = ($urandom_range(0, 299) != 0);
            cyc(rn, a, u, d, o, c);
        end
        drv_done = 1'b1;
    end

    // Wrap up once the driver is done and the queue has drained (bounded).
    initial begin
        wait (drv_done);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge CLK);
        @(negedge CLK);
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain actual=%0d expected=0 pending entries", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "bench time limit");
    end

endmodule
